// File: rtl/io_clk_divider_bank.sv
// io_clk_divider_bank: eight programmable 50%-duty clock dividers behind a valid/ready config port.
// New half-periods are held pending and applied only when a channel is idle or at its falling edge.
module io_clk_divider_bank #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 sys_clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    input  logic                 cfg_valid,
    output logic                 cfg_ready,
    input  logic [3:0]           cfg_addr,
    input  logic [DIV_WIDTH-1:0] cfg_data,
    output logic [7:0]           divided_clks,
    output logic [7:0]           tick_out,
    output logic [3:0][1:0]      divided_clk_sels
);

    localparam int NCH = 8;
    localparam logic [DIV_WIDTH-1:0] ONE = DIV_WIDTH'(1);

    logic [DIV_WIDTH-1:0] r_hp   [NCH];
    logic [DIV_WIDTH-1:0] r_cnt  [NCH];
    logic [DIV_WIDTH-1:0] r_pend [NCH];
    logic [NCH-1:0]       r_lvl;
    logic [NCH-1:0]       r_pend_v;
    logic [NCH-1:0]       r_tick;
    logic [3:0][1:0]      r_sels;

    logic                 w_cfg_ready;
    logic                 w_accept;
    logic                 w_sel_wr;
    logic [NCH-1:0]       w_wr_ch;
    logic [NCH-1:0]       w_running;
    logic [NCH-1:0]       w_term;

    // A channel refuses a second write until its pending value has been consumed.
    always_comb begin
        w_wr_ch   = '0;
        w_running = '0;
        w_term    = '0;
        w_cfg_ready = cfg_addr[3] | ~r_pend_v[cfg_addr[2:0]];
        w_accept    = cfg_valid & w_cfg_ready & clk_en;
        w_sel_wr    = w_accept & (cfg_addr == 4'd8);
        for (int i = 0; i < NCH; i++) begin
            w_wr_ch[i]   = w_accept & ~cfg_addr[3] & (cfg_addr[2:0] == 3'(i));
            w_running[i] = (r_hp[i] != '0);
            w_term[i]    = (r_cnt[i] == r_hp[i] - ONE);
        end
    end

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                r_hp[i]   <= '0;
                r_cnt[i]  <= '0;
                r_pend[i] <= '0;
            end
            r_lvl    <= '0;
            r_pend_v <= '0;
            r_tick   <= '0;
            r_sels   <= '0;
        end else if (clk_en) begin
            if (w_sel_wr) begin
                for (int k = 0; k < 4; k++) begin
                    r_sels[k] <= cfg_data[2*k +: 2];
                end
            end
            for (int i = 0; i < NCH; i++) begin
                r_tick[i] <= 1'b0;
                // A write can never meet an apply here: writes need pend_v low, applies need it high.
                if (w_wr_ch[i]) begin
                    r_pend[i]   <= cfg_data;
                    r_pend_v[i] <= 1'b1;
                end
                if (!w_running[i]) begin
                    r_cnt[i] <= '0;
                    r_lvl[i] <= 1'b0;
                    if (r_pend_v[i]) begin
                        r_hp[i]     <= r_pend[i];
                        r_pend_v[i] <= 1'b0;
                    end
                end else if (!w_term[i]) begin
                    r_cnt[i] <= r_cnt[i] + ONE;
                end else begin
                    r_cnt[i]  <= '0;
                    r_lvl[i]  <= ~r_lvl[i];
                    r_tick[i] <= ~r_lvl[i];
                    if (r_lvl[i] && r_pend_v[i]) begin
                        r_hp[i]     <= r_pend[i];
                        r_pend_v[i] <= 1'b0;
                    end
                end
            end
        end else begin
            r_tick <= '0;
        end
    end

    assign cfg_ready        = w_cfg_ready;
    assign divided_clks     = r_lvl;
    assign tick_out         = r_tick;
    assign divided_clk_sels = r_sels;

endmodule

// File: tb/tb_io_clk_divider_bank.sv
// tb_io_clk_divider_bank: directed table, corner sequences and random traffic checked
// against a period-position model of each divider channel.
module tb_io_clk_divider_bank;

    localparam int DW = 16;

    logic            sys_clk = 1'b0;
    logic            rst_n;
    logic            clk_en;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [3:0]      cfg_addr;
    logic [DW-1:0]   cfg_data;
    logic [7:0]      divided_clks;
    logic [7:0]      tick_out;
    logic [3:0][1:0] divided_clk_sels;

    always #5 sys_clk = ~sys_clk;

    io_clk_divider_bank #(.DIV_WIDTH(DW)) dut (
        .sys_clk          (sys_clk),
        .rst_n            (rst_n),
        .clk_en           (clk_en),
        .cfg_valid        (cfg_valid),
        .cfg_ready        (cfg_ready),
        .cfg_addr         (cfg_addr),
        .cfg_data         (cfg_data),
        .divided_clks     (divided_clks),
        .tick_out         (tick_out),
        .divided_clk_sels (divided_clk_sels)
    );

    typedef struct {
        logic        en;
        logic        valid;
        logic [3:0]  addr;
        logic [15:0] data;
        logic [7:0]  expClks;
        logic [7:0]  expTick;
        logic [7:0]  expSels;
        logic        expReady;
    } vec_t;

    vec_t vecs[16];
    int   vectors = 0;
    int   miscompares = 0;

    // Each channel is modelled as a position within its 2*hp period: low while pos < hp.
    int       mHp[8];
    int       mPos[8];
    int       mPend[8];
    bit       mPv[8];
    bit [7:0] mTick;
    bit [7:0] mSels;

    function automatic void modelReset();
        for (int i = 0; i < 8; i++) begin
            mHp[i] = 0; mPos[i] = 0; mPend[i] = 0; mPv[i] = 0;
        end
        mTick = '0;
        mSels = '0;
    endfunction

    function automatic bit modelReady(input logic [3:0] a);
        return a[3] ? 1'b1 : !mPv[a[2:0]];
    endfunction

    function automatic bit modelLvl(input int ch);
        return (mHp[ch] != 0) && (mPos[ch] >= mHp[ch]);
    endfunction

    function automatic bit [7:0] modelClks();
        bit [7:0] c = '0;
        for (int i = 0; i < 8; i++) c[i] = modelLvl(i);
        return c;
    endfunction

    function automatic void modelStep(input logic en, input logic valid,
                                      input logic [3:0] addr, input logic [15:0] data);
        bit acc;
        mTick = '0;
        if (!en) return;
        acc = valid && modelReady(addr);
        for (int i = 0; i < 8; i++) begin
            if (mHp[i] == 0) begin
                if (mPv[i]) begin
                    mHp[i] = mPend[i]; mPv[i] = 0; mPos[i] = 0;
                end
            end else begin
                mPos[i]++;
                if (mPos[i] == 2 * mHp[i]) begin
                    mPos[i] = 0;
                    if (mPv[i]) begin
                        mHp[i] = mPend[i]; mPv[i] = 0;
                    end
                end else if (mPos[i] == mHp[i]) begin
                    mTick[i] = 1'b1;
                end
            end
        end
        if (acc) begin
            if (!addr[3]) begin
                mPend[addr[2:0]] = int'(data);
                mPv[addr[2:0]] = 1'b1;
            end else if (addr == 4'd8) begin
                mSels = data[7:0];
            end
        end
    endfunction

    task automatic setVec(input int idx, input logic en, input logic valid, input logic [3:0] addr,
                          input logic [15:0] data, input logic [7:0] eClks, input logic [7:0] eTick,
                          input logic [7:0] eSels, input logic eReady);
        vecs[idx] = '{en, valid, addr, data, eClks, eTick, eSels, eReady};
    endtask

    task automatic applyStimulus(input logic en, input logic valid,
                                 input logic [3:0] addr, input logic [15:0] data);
        clk_en    = en;
        cfg_valid = valid;
        cfg_addr  = addr;
        cfg_data  = data;
        modelStep(en, valid, addr, data);
        @(negedge sys_clk);
    endtask

    task automatic checkVec(input string name, input logic [7:0] eClks, input logic [7:0] eTick,
                            input logic [7:0] eSels, input logic eReady);
        vectors++;
        if (divided_clks !== eClks || tick_out !== eTick ||
            divided_clk_sels !== eSels || cfg_ready !== eReady) begin
            miscompares++;
            $display("[TB] FAIL %s: got clks=%h tick=%h sels=%h ready=%b, want clks=%h tick=%h sels=%h ready=%b",
                     name, divided_clks, tick_out, divided_clk_sels, cfg_ready,
                     eClks, eTick, eSels, eReady);
        end
    endtask

    task automatic checkOutput(input string name);
        checkVec(name, modelClks(), mTick, mSels, modelReady(cfg_addr));
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %b, want %b", name, actual, expected);
        end
    endtask

    task automatic waitHigh(input int ch, input int bound);
        int n = 0;
        while (!modelLvl(ch) && n < bound) begin
            applyStimulus(1'b1, 1'b0, 4'(ch), 16'd0);
            checkOutput("wait_high");
            n++;
        end
        checkBit("wait_high_bound", modelLvl(ch), 1'b1);
    endtask

    initial begin
        logic hist[12];
        int   runStart;
        bit   lenOk;

        rst_n = 1'b0; clk_en = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0;
        modelReset();
        #2;
        checkVec("reset_state", 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst_n = 1'b1;

        for (int k = 0; k < 100; k++) begin
            applyStimulus(1'b1, 1'b0, 4'(k % 16), 16'd0);
            checkOutput("idle_after_reset");
        end

        // Directed table: ch0 = 3 from disabled, select write, ignored address, clk_en low.
        setVec( 0, 1, 1, 4'd0,  16'h0003, 8'h00, 8'h00, 8'h00, 1'b0);
        setVec( 1, 1, 0, 4'd0,  16'h0000, 8'h00, 8'h00, 8'h00, 1'b1);
        setVec( 2, 1, 0, 4'd0,  16'h0000, 8'h00, 8'h00, 8'h00, 1'b1);
        setVec( 3, 1, 0, 4'd0,  16'h0000, 8'h00, 8'h00, 8'h00, 1'b1);
        setVec( 4, 1, 0, 4'd0,  16'h0000, 8'h01, 8'h01, 8'h00, 1'b1);
        setVec( 5, 1, 0, 4'd0,  16'h0000, 8'h01, 8'h00, 8'h00, 1'b1);
        setVec( 6, 1, 0, 4'd0,  16'h0000, 8'h01, 8'h00, 8'h00, 1'b1);
        setVec( 7, 1, 0, 4'd0,  16'h0000, 8'h00, 8'h00, 8'h00, 1'b1);
        setVec( 8, 1, 0, 4'd0,  16'h0000, 8'h00, 8'h00, 8'h00, 1'b1);
        setVec( 9, 1, 0, 4'd0,  16'h0000, 8'h00, 8'h00, 8'h00, 1'b1);
        setVec(10, 1, 0, 4'd0,  16'h0000, 8'h01, 8'h01, 8'h00, 1'b1);
        setVec(11, 1, 1, 4'd8,  16'h00E4, 8'h01, 8'h00, 8'hE4, 1'b1);
        setVec(12, 1, 1, 4'd12, 16'hFFFF, 8'h01, 8'h00, 8'hE4, 1'b1);
        setVec(13, 1, 0, 4'd0,  16'h0000, 8'h00, 8'h00, 8'hE4, 1'b1);
        setVec(14, 0, 1, 4'd1,  16'h0002, 8'h00, 8'h00, 8'hE4, 1'b1);
        setVec(15, 1, 0, 4'd1,  16'h0000, 8'h00, 8'h00, 8'hE4, 1'b1);
        for (int r = 0; r < 16; r++) begin
            applyStimulus(vecs[r].en, vecs[r].valid, vecs[r].addr, vecs[r].data);
            checkVec($sformatf("table_row%0d", r), vecs[r].expClks, vecs[r].expTick,
                     vecs[r].expSels, vecs[r].expReady);
        end

        // ch0 retuned from 3 to 1 during its high phase.
        waitHigh(0, 8);
        applyStimulus(1'b1, 1'b1, 4'd0, 16'd1);
        checkOutput("seqA_write");
        checkBit("seqA_ready_low", cfg_ready, 1'b0);
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b0, 4'd0, 16'd0);
            checkOutput("seqA_run");
            hist[k] = divided_clks[0];
        end
        runStart = -1;
        lenOk = 1'b1;
        for (int k = 1; k < 12; k++) begin
            if (hist[k] != hist[k-1]) begin
                if (runStart >= 0 && (k - runStart < 1 || k - runStart > 3)) lenOk = 1'b0;
                runStart = k;
            end
        end
        checkBit("seqA_phase_len", lenOk, 1'b1);
        checkBit("seqA_period2", (hist[9] != hist[10]) && (hist[10] != hist[11]), 1'b1);

        // ch2 at hp=5 disabled by a pending 0, then restarted with hp=2.
        applyStimulus(1'b1, 1'b1, 4'd2, 16'd5);
        checkOutput("seqB_write5");
        waitHigh(2, 16);
        applyStimulus(1'b1, 1'b1, 4'd2, 16'd0);
        checkOutput("seqB_write0");
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b1, 1'b0, 4'd2, 16'd0);
            checkOutput("seqB_drain");
        end
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, 1'b0, 4'd2, 16'd0);
            checkBit("seqB_stays_low", divided_clks[2], 1'b0);
        end
        applyStimulus(1'b1, 1'b1, 4'd2, 16'd2);
        checkOutput("seqB_write2");
        for (int k = 1; k <= 3; k++) begin
            applyStimulus(1'b1, 1'b0, 4'd2, 16'd0);
            checkOutput("seqB_restart_model");
            checkBit("seqB_restart_clk", divided_clks[2], k == 3);
            checkBit("seqB_restart_tick", tick_out[2], k == 3);
        end

        // ch1 frozen by clk_en, then reset asynchronously mid-high-phase.
        applyStimulus(1'b1, 1'b1, 4'd1, 16'd4);
        checkOutput("seqC_write4");
        waitHigh(1, 16);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b1, 4'd3, 16'd3);
            checkOutput("seqC_frozen");
            checkBit("seqC_frozen_high", divided_clks[1], 1'b1);
            checkBit("seqC_no_tick", tick_out[1], 1'b0);
        end
        #3 rst_n = 1'b0;
        #1;
        modelReset();
        checkVec("seqC_async_reset", 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge sys_clk);
        rst_n = 1'b1;
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1'b1, 1'b0, 4'd1, 16'd0);
            checkOutput("seqC_after_reset");
            checkBit("seqC_ch1_disabled", divided_clks[1], 1'b0);
        end

        // Random traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            logic       en;
            logic       valid;
            logic [3:0] addr;
            logic [15:0] data;
            en    = ($urandom_range(0, 9) != 0);
            valid = $urandom_range(0, 1) == 1;
            addr  = 4'($urandom_range(0, 15));
            data  = addr[3] ? 16'($urandom) : 16'($urandom_range(0, 6));
            applyStimulus(en, valid, addr, data);
            checkOutput("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
